// File: rtl/seg4_scan.sv
// Time-multiplexed 4-digit seven-segment driver: hex decode, per-digit blanking,
// decimal points and an anti-ghost dead time at the start of every digit slot.
`timescale 1ns/1ps
module seg4_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 4,
  parameter int COMMON_ANODE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        scan_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);
  localparam logic          INV      = (COMMON_ANODE != 0);
  localparam logic [3:0]    AN_OFF   = {4{INV}};
  localparam logic [6:0]    SEG_OFF  = {7{INV}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick_q, tick_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap;
  logic          active;
  logic [3:0]    nibble;

  // Active-high gfedcba pattern; polarity is applied after the mux.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    tick_d = 1'b0;
    wrap   = (cnt_q == CNT_LAST);
    if (wrap) begin
      cnt_d  = '0;
      idx_d  = idx_q + 2'd1;
      tick_d = 1'b1;
    end

    // Outputs come from the current cnt/idx, so the registered anode is
    // always one-hot or off, even on the cycle idx advances.
    nibble = digits[{idx_q, 2'b00} +: 4];
    active = (cnt_q >= BLANK_V) && digit_en[idx_q];
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    dp_d   = INV;
    if (active) begin
      an_d  = (4'b0001 << idx_q) ^ AN_OFF;
      seg_d = hex7(nibble) ^ SEG_OFF;
      dp_d  = dp_in[idx_q] ^ INV;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      tick_q <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= INV;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg4_scan.sv
// Directed bench for seg4_scan: common-anode build with dead time, plus a
// common-cathode build without dead time sharing the same inputs.
`timescale 1ns/1ps
module tb_seg4_scan;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        tick_a, tick_b;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  // Active-high decode table, written out independently of the RTL.
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] an_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // digits = 16'h1234 shown on slots 0..3, common-anode patterns
  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  seg4_scan #(.REFRESH_DIV(8), .BLANK_CYC(2), .COMMON_ANODE(1)) u_dut_a (
    .clock(clk), .reset_n(rst_a_n), .digits(digits), .digit_en(digit_en),
    .dp_in(dp_in), .seg(seg_a), .dp(dp_a), .an(an_a), .scan_tick(tick_a)
  );

  seg4_scan #(.REFRESH_DIV(8), .BLANK_CYC(0), .COMMON_ANODE(0)) u_dut_b (
    .clock(clk), .reset_n(rst_b_n), .digits(digits), .digit_en(digit_en),
    .dp_in(dp_in), .seg(seg_b), .dp(dp_b), .an(an_b), .scan_tick(tick_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, obs, exp);
    else
      n_pass++;
  endtask

  // one active edge, then settle to the negedge for sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    k = 0;
  endtask

  // slot/count that produced the outputs visible after edge k
  function automatic int slot_of(input int kk);
    return ((kk - 1) / 8) % 4;
  endfunction
  function automatic int cnt_of(input int kk);
    return (kk - 1) % 8;
  endfunction

  initial begin
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    digits   = 16'h1234;
    digit_en = 4'hF;
    dp_in    = 4'h0;

    // reset holds everything off
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_an", an_a, 4'b1111);
      check("rst_seg", seg_a, 7'h7F);
      check("rst_dp", dp_a, 1'b1);
      check("rst_tick", tick_a, 1'b0);
    end
    check("rst_b_an", an_b, 4'b0000);
    check("rst_b_seg", seg_b, 7'h00);

    // scan order and timing with 1234, all enabled
    rst_a_n = 1'b1;
    k = 0;
    for (int i = 0; i < 34; i++) begin
      step();
      if (cnt_of(k) >= 2) begin
        check("scan_an", an_a, an_sel[slot_of(k)]);
        check("scan_seg", seg_a, seg_1234[slot_of(k)]);
      end else begin
        check("scan_an_blank", an_a, 4'b1111);
        check("scan_seg_blank", seg_a, 7'h7F);
      end
      check("scan_dp", dp_a, 1'b1);
      check("scan_tick", tick_a, (k % 8 == 0) ? 1 : 0);
    end

    // full decode sweep on digit 0 only
    digit_en = 4'b0001;
    reset_a();
    for (int v = 0; v < 16; v++) begin
      digits = 16'(v);
      for (int j = 0; j < 32; j++) begin
        step();
        if (j == 4) begin
          check("dec_seg", seg_a, ~hex_tbl[v] & 7'h7F);
          check("dec_an", an_a, 4'b1110);
        end
        if (j == 11 || j == 19 || j == 27) check("dec_off_an", an_a, 4'b1111);
      end
    end

    // blanking and decimal points
    digits   = 16'h1234;
    digit_en = 4'b1010;
    dp_in    = 4'b0010;
    reset_a();
    for (int i = 0; i < 32; i++) begin
      step();
      if (cnt_of(k) >= 2 && slot_of(k) == 1) begin
        check("bl_an1", an_a, 4'b1101);
        check("bl_seg1", seg_a, 7'h30);
        check("bl_dp1", dp_a, 1'b0);
      end else if (cnt_of(k) >= 2 && slot_of(k) == 3) begin
        check("bl_an3", an_a, 4'b0111);
        check("bl_seg3", seg_a, 7'h79);
        check("bl_dp3", dp_a, 1'b1);
      end else begin
        check("bl_an_off", an_a, 4'b1111);
        check("bl_seg_off", seg_a, 7'h7F);
        check("bl_dp_off", dp_a, 1'b1);
      end
    end

    // asynchronous reset in the middle of slot 2
    digit_en = 4'hF;
    dp_in    = 4'h0;
    reset_a();
    for (int i = 0; i < 21; i++) step();
    check("mid_pre_an", an_a, 4'b1011);
    rst_a_n = 1'b0;
    #1;
    check("mid_async_an", an_a, 4'b1111);
    check("mid_async_seg", seg_a, 7'h7F);
    check("mid_async_dp", dp_a, 1'b1);
    @(negedge clk);
    rst_a_n = 1'b1;
    k = 0;
    step();
    check("mid_rel_k1_an", an_a, 4'b1111);
    check("mid_rel_k1_tick", tick_a, 1'b0);
    step();
    check("mid_rel_k2_an", an_a, 4'b1111);
    step();
    check("mid_rel_k3_an", an_a, 4'b1110);
    check("mid_rel_k3_seg", seg_a, 7'h19);

    // common-cathode build, no dead time
    digits = 16'h000F;
    @(negedge clk);
    rst_b_n = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      check("b_onehot", {31'b0, $onehot(an_b)}, 32'd1);
      check("b_an", an_b, 4'(4'b0001 << slot_of(k)));
      check("b_seg", seg_b, (slot_of(k) == 0) ? 7'h71 : 7'h3F);
      check("b_dp", dp_b, 1'b0);
      check("b_tick", tick_b, (k % 8 == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
